// File: rtl/tcam_filter_array.sv
// tcam_filter_array
//   Programmable ternary-match packet filter. A {tag, opcode, NID} key is
//   compared against DEPTH entries, each holding value/care-mask pairs. The
//   flag of the lowest-index matching entry is returned through a two-stage
//   valid/ready pipeline: S1 holds the accepted key, S2 is the output register.
//
// Ports
//   clk, reset                 : clock (rising edge), async active-high reset
//   in_valid / in_ready        : lookup key handshake
//   tag, opcode, NID           : lookup key
//   wr_en, wr_idx              : write one entry (indexes >= DEPTH ignored)
//   wr_entry_valid             : valid bit stored with the entry
//   wr_*_val / wr_*_mask       : per-field value and care mask (1 = compare)
//   wr_flag                    : flag returned on a hit
//   clear_all                  : invalidate every entry (a same-cycle write still lands)
//   out_valid / out_ready      : result handshake
//   flag, hit, hit_idx         : result; all zero on a miss
//
// Build option
//   TCAM_HIT_CNT_EN : adds saturating 32-bit hit_cnt / miss_cnt outputs that
//                     count lookups moving S1->S2; cleared by reset and clear_all.

module tcam_filter_array #(
  parameter int TAG_W  = 33,
  parameter int OP_W   = 7,
  parameter int NID_W  = 7,
  parameter int DEPTH  = 16,
  parameter int FLAG_W = 4,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  tag,
  input  logic [OP_W-1:0]   opcode,
  input  logic [NID_W-1:0]  NID,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_entry_valid,
  input  logic [TAG_W-1:0]  wr_tag_val,
  input  logic [TAG_W-1:0]  wr_tag_mask,
  input  logic [OP_W-1:0]   wr_op_val,
  input  logic [OP_W-1:0]   wr_op_mask,
  input  logic [NID_W-1:0]  wr_nid_val,
  input  logic [NID_W-1:0]  wr_nid_mask,
  input  logic [FLAG_W-1:0] wr_flag,
  input  logic              clear_all,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLAG_W-1:0] flag,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
`ifdef TCAM_HIT_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  // Entry storage; only the valid bits need a reset value.
  logic [DEPTH-1:0]  r_entValid;
  logic [TAG_W-1:0]  r_tagVal  [DEPTH];
  logic [TAG_W-1:0]  r_tagMask [DEPTH];
  logic [OP_W-1:0]   r_opVal   [DEPTH];
  logic [OP_W-1:0]   r_opMask  [DEPTH];
  logic [NID_W-1:0]  r_nidVal  [DEPTH];
  logic [NID_W-1:0]  r_nidMask [DEPTH];
  logic [FLAG_W-1:0] r_entFlag [DEPTH];

  // Pipeline registers.
  logic              r_s1Valid;
  logic [TAG_W-1:0]  r_s1Tag;
  logic [OP_W-1:0]   r_s1Op;
  logic [NID_W-1:0]  r_s1Nid;
  logic              r_outValid;
  logic [FLAG_W-1:0] r_outFlag;
  logic              r_outHit;
  logic [IDX_W-1:0]  r_outIdx;

  logic              w_s2Adv;
  logic              w_accept;
  logic              w_xfer;
  logic              w_wrOk;
  logic [IDX_W:0]    w_wrIdxExt;
  logic [DEPTH-1:0]  w_match;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hitIdx;
  logic [FLAG_W-1:0] w_flag;

  assign w_s2Adv  = !r_outValid || out_ready;
  assign in_ready = !r_s1Valid || w_s2Adv;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_s1Valid && w_s2Adv;

  // One extra bit keeps the range check meaningful even when DEPTH is a power of two.
  assign w_wrIdxExt = {1'b0, wr_idx};
  assign w_wrOk     = wr_en && (w_wrIdxExt < (IDX_W+1)'(DEPTH));

  // clear_all first, then the write, so a combined clear+write leaves only that entry valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entValid <= '0;
    end else begin
      if (clear_all) r_entValid <= '0;
      if (w_wrOk)    r_entValid[wr_idx] <= wr_entry_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrOk) begin
      r_tagVal[wr_idx]  <= wr_tag_val;
      r_tagMask[wr_idx] <= wr_tag_mask;
      r_opVal[wr_idx]   <= wr_op_val;
      r_opMask[wr_idx]  <= wr_op_mask;
      r_nidVal[wr_idx]  <= wr_nid_val;
      r_nidMask[wr_idx] <= wr_nid_mask;
      r_entFlag[wr_idx] <= wr_flag;
    end
  end

  // Ternary compare of the S1 key against the pre-edge table contents, so a
  // write on the transfer edge is not seen by the lookup moving to S2.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_entValid[i]
                && (((r_s1Tag ^ r_tagVal[i])  & r_tagMask[i]) == '0)
                && (((r_s1Op  ^ r_opVal[i])   & r_opMask[i])  == '0)
                && (((r_s1Nid ^ r_nidVal[i])  & r_nidMask[i]) == '0);
    end
  end

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    w_flag   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit    = 1'b1;
        w_hitIdx = IDX_W'(i);
        w_flag   = r_entFlag[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
    end else if (w_accept) begin
      r_s1Valid <= 1'b1;
    end else if (w_s2Adv) begin
      r_s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1Tag <= tag;
      r_s1Op  <= opcode;
      r_s1Nid <= NID;
    end
  end

  // Output register only moves when the consumer can take data, which holds
  // the result stable during backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outFlag  <= '0;
      r_outHit   <= 1'b0;
      r_outIdx   <= '0;
    end else if (w_s2Adv) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outFlag <= w_flag;
        r_outHit  <= w_hit;
        r_outIdx  <= w_hitIdx;
      end
    end
  end

  assign out_valid = r_outValid;
  assign flag      = r_outFlag;
  assign hit       = r_outHit;
  assign hit_idx   = r_outIdx;

`ifdef TCAM_HIT_CNT_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;

  // Saturating counters; clear_all wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (clear_all) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (w_xfer) begin
      if (w_hit && (r_hitCnt != 32'hFFFF_FFFF))    r_hitCnt  <= r_hitCnt + 32'd1;
      if (!w_hit && (r_missCnt != 32'hFFFF_FFFF))  r_missCnt <= r_missCnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hitCnt;
  assign miss_cnt = r_missCnt;
`else
  // Transfer strobe only feeds the optional counters.
  logic w_xferUnused;
  assign w_xferUnused = w_xfer;
`endif

endmodule

// File: tb/tb_tcam_filter_array.sv
// tb_tcam_filter_array
//   Self-checking bench for tcam_filter_array. A reference table model gives
//   the expected lookup results; they are queued as keys are accepted and
//   compared as results are consumed. Define TCAM_HIT_CNT_EN to also check
//   the hit/miss counters.

module tb_tcam_filter_array;

  localparam int TAG_W  = 33;
  localparam int OP_W   = 7;
  localparam int NID_W  = 7;
  localparam int DEPTH  = 16;
  localparam int FLAG_W = 4;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  tag;
  logic [OP_W-1:0]   opcode;
  logic [NID_W-1:0]  NID;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_entry_valid;
  logic [TAG_W-1:0]  wr_tag_val, wr_tag_mask;
  logic [OP_W-1:0]   wr_op_val, wr_op_mask;
  logic [NID_W-1:0]  wr_nid_val, wr_nid_mask;
  logic [FLAG_W-1:0] wr_flag;
  logic              clear_all;
  logic              out_valid;
  logic              out_ready;
  logic [FLAG_W-1:0] flag;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
`ifdef TCAM_HIT_CNT_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  tcam_filter_array #(
    .TAG_W(TAG_W), .OP_W(OP_W), .NID_W(NID_W), .DEPTH(DEPTH), .FLAG_W(FLAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .tag(tag), .opcode(opcode), .NID(NID),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_entry_valid(wr_entry_valid),
    .wr_tag_val(wr_tag_val), .wr_tag_mask(wr_tag_mask),
    .wr_op_val(wr_op_val), .wr_op_mask(wr_op_mask),
    .wr_nid_val(wr_nid_val), .wr_nid_mask(wr_nid_mask),
    .wr_flag(wr_flag), .clear_all(clear_all),
    .out_valid(out_valid), .out_ready(out_ready),
    .flag(flag), .hit(hit), .hit_idx(hit_idx)
`ifdef TCAM_HIT_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [FLAG_W-1:0] flg;
  } res_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [NID_W-1:0]  nid;
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [FLAG_W-1:0] flg;
  } vec_t;

  int testsRun  = 0;
  int failCount = 0;

  res_t scoreQ[$];
  res_t curExp;
  logic monEn = 1'b0;
  logic patEn = 1'b0;
  int   patCyc = 0;

  // Reference table.
  logic              mValid   [DEPTH];
  logic [TAG_W-1:0]  mTagVal  [DEPTH], mTagMask [DEPTH];
  logic [OP_W-1:0]   mOpVal   [DEPTH], mOpMask  [DEPTH];
  logic [NID_W-1:0]  mNidVal  [DEPTH], mNidMask [DEPTH];
  logic [FLAG_W-1:0] mFlag    [DEPTH];

  function automatic res_t refLookup(input logic [TAG_W-1:0] t, input logic [OP_W-1:0] o,
                                     input logic [NID_W-1:0] n);
    res_t r;
    r.hit = 1'b0; r.idx = '0; r.flg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mValid[i] && ((t & mTagMask[i]) == (mTagVal[i] & mTagMask[i]))
                    && ((o & mOpMask[i])  == (mOpVal[i]  & mOpMask[i]))
                    && ((n & mNidMask[i]) == (mNidVal[i] & mNidMask[i]))) begin
        r.hit = 1'b1; r.idx = IDX_W'(i); r.flg = mFlag[i];
        return r;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (patEn) begin
      out_ready = (patCyc % 3 == 0);
      patCyc++;
    end
  endtask

  task automatic applyStimulus(input logic [TAG_W-1:0] t, input logic [OP_W-1:0] o,
                               input logic [NID_W-1:0] n, input res_t exp);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    in_valid = 1'b1; tag = t; opcode = o; NID = n; curExp = exp;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      failCount++;
      $display("[TB] FAIL acceptTimeout: got in_ready=0, expected 1 within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic writeEntry(input logic clr, input int idx, input logic v,
                            input logic [TAG_W-1:0] tv, input logic [TAG_W-1:0] tm,
                            input logic [OP_W-1:0] ov, input logic [OP_W-1:0] om,
                            input logic [NID_W-1:0] nv, input logic [NID_W-1:0] nm,
                            input logic [FLAG_W-1:0] f);
    clear_all = clr;
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_entry_valid = v;
    wr_tag_val = tv; wr_tag_mask = tm; wr_op_val = ov; wr_op_mask = om;
    wr_nid_val = nv; wr_nid_mask = nm; wr_flag = f;
    tick();
    wr_en = 1'b0; clear_all = 1'b0;
    if (clr) for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    mValid[idx] = v; mTagVal[idx] = tv; mTagMask[idx] = tm; mOpVal[idx] = ov;
    mOpMask[idx] = om; mNidVal[idx] = nv; mNidMask[idx] = nm; mFlag[idx] = f;
  endtask

  task automatic clearTable();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (scoreQ.size() > 0 && g < 100) begin
      tick();
      g++;
    end
    if (scoreQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", scoreQ.size());
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  logic              prevStall = 1'b0;
  logic [FLAG_W-1:0] prevFlag;
  logic              prevHit;
  logic [IDX_W-1:0]  prevIdx;

  always @(negedge clk) begin
    res_t r;
    if (monEn && !reset) begin
      if (prevStall) begin
        checkOutput("holdValid", out_valid, 1'b1);
        checkOutput("holdFlag", flag, prevFlag);
        checkOutput("holdHit", hit, prevHit);
        checkOutput("holdIdx", hit_idx, prevIdx);
      end
      checkOutput("inReady", in_ready, !(scoreQ.size() >= 2 && !out_ready));
      if (out_valid && out_ready) begin
        if (scoreQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpectedResult: got out_valid=1, expected no result pending");
        end else begin
          r = scoreQ.pop_front();
          checkOutput("resHit", hit, r.hit);
          checkOutput("resIdx", hit_idx, r.idx);
          checkOutput("resFlag", flag, r.flg);
        end
      end
      if (in_valid && in_ready) scoreQ.push_back(curExp);
      prevStall = out_valid && !out_ready;
      prevFlag  = flag;
      prevHit   = hit;
      prevIdx   = hit_idx;
    end
  end

  initial begin
    vec_t vecs[$];
    logic [TAG_W-1:0] kaTag, kbTag, kcTag, k7Tag, allTag, bitTag;
    logic [OP_W-1:0]  kaOp, kbOp, kcOp, k7Op, allOp;
    logic [NID_W-1:0] kaNid, kbNid, kcNid, k7Nid, allNid;
    res_t missRes, e;

    kaTag = 33'h1_2345_6789; kaOp = 7'b0000111; kaNid = 7'b0000010;
    kbTag = 33'h0_0BAD_F00D; kbOp = 7'h55;      kbNid = 7'h2A;
    kcTag = 33'h1_FFFF_0000; kcOp = 7'h11;      kcNid = 7'h22;
    k7Tag = 33'h0_7777_7777; k7Op = 7'h07;      k7Nid = 7'h70;
    allTag = '1; allOp = '1; allNid = '1;
    bitTag = 33'h1;
    missRes.hit = 1'b0; missRes.idx = '0; missRes.flg = '0;
    for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;

    in_valid = 1'b0; tag = '0; opcode = '0; NID = '0;
    wr_en = 1'b0; wr_idx = '0; wr_entry_valid = 1'b0;
    wr_tag_val = '0; wr_tag_mask = '0; wr_op_val = '0; wr_op_mask = '0;
    wr_nid_val = '0; wr_nid_mask = '0; wr_flag = '0; clear_all = 1'b0;
    out_ready = 1'b1;
    curExp = missRes;

    reset = 1'b1;
    #23;
    checkOutput("rstOutValid", out_valid, 1'b0);
    checkOutput("rstHit", hit, 1'b0);
    checkOutput("rstFlag", flag, '0);
    checkOutput("rstHitIdx", hit_idx, '0);
    checkOutput("rstInReady", in_ready, 1'b1);
    reset = 1'b0;
    tick();
    monEn = 1'b1;

    // Lookup on an empty table: result appears one edge after the accepting edge.
    applyStimulus(33'h0_0000_0001, 7'b0000001, 7'b0000001, missRes);
    checkOutput("latencyEdge1", out_valid, 1'b0);
    tick();
    checkOutput("latencyEdge2", out_valid, 1'b1);
    waitDrain();

    // Exact entry 3.
    writeEntry(1'b0, 3, 1'b1, kaTag, allTag, kaOp, allOp, kaNid, allNid, 4'hA);
    vecs.push_back('{kaTag, kaOp, kaNid, 1'b1, IDX_W'(3), 4'hA});
    vecs.push_back('{kaTag ^ bitTag, kaOp, kaNid, 1'b0, IDX_W'(0), 4'h0});
    vecs.push_back('{kaTag, kaOp ^ 7'h01, kaNid, 1'b0, IDX_W'(0), 4'h0});
    vecs.push_back('{kbTag, kbOp, kbNid, 1'b0, IDX_W'(0), 4'h0});
    foreach (vecs[v]) begin
      e.hit = vecs[v].hit; e.idx = vecs[v].idx; e.flg = vecs[v].flg;
      applyStimulus(vecs[v].tag, vecs[v].op, vecs[v].nid, e);
    end
    waitDrain();

    // Wildcard entry 5 below exact entry 2; entry 3 still beats the wildcard.
    writeEntry(1'b0, 5, 1'b1, '0, '0, '0, '0, '0, '0, 4'h1);
    writeEntry(1'b0, 2, 1'b1, kbTag, allTag, kbOp, allOp, kbNid, allNid, 4'h7);
    vecs.delete();
    vecs.push_back('{kbTag, kbOp, kbNid, 1'b1, IDX_W'(2), 4'h7});
    vecs.push_back('{kaTag, kaOp, kaNid, 1'b1, IDX_W'(3), 4'hA});
    vecs.push_back('{kaTag ^ bitTag, kaOp, kaNid, 1'b1, IDX_W'(5), 4'h1});
    vecs.push_back('{33'h0, 7'h0, 7'h0, 1'b1, IDX_W'(5), 4'h1});
    vecs.push_back('{kbTag, kbOp, kbNid ^ 7'h01, 1'b1, IDX_W'(5), 4'h1});
    foreach (vecs[v]) begin
      e.hit = vecs[v].hit; e.idx = vecs[v].idx; e.flg = vecs[v].flg;
      applyStimulus(vecs[v].tag, vecs[v].op, vecs[v].nid, e);
    end
    waitDrain();

    // Back-to-back lookups under a 1,0,0 out_ready pattern.
    patEn = 1'b1; patCyc = 0;
    for (int k = 0; k < 8; k++) begin
      logic [TAG_W-1:0] t;
      logic [OP_W-1:0]  o;
      logic [NID_W-1:0] n;
      case (k % 3)
        0:       begin t = kaTag;                o = kaOp; n = kaNid; end
        1:       begin t = kbTag;                o = kbOp; n = kbNid; end
        default: begin t = 33'(k) ^ kbTag;       o = 7'(k); n = kbNid; end
      endcase
      applyStimulus(t, o, n, refLookup(t, o, n));
    end
    waitDrain();
    patEn = 1'b0; out_ready = 1'b1;

    // Write on the transfer edge is invisible to that lookup.
    clearTable();
    applyStimulus(kcTag, kcOp, kcNid, missRes);
    writeEntry(1'b0, 0, 1'b1, kcTag, allTag, kcOp, allOp, kcNid, allNid, 4'hC);
    applyStimulus(kcTag, kcOp, kcNid, refLookup(kcTag, kcOp, kcNid));
    checkOutput("modelKcIdx", refLookup(kcTag, kcOp, kcNid).flg, kcTag[3:0] ^ 4'hC);
    waitDrain();

    // clear_all with a simultaneous write: only entry 7 survives.
    writeEntry(1'b0, 3, 1'b1, kaTag, allTag, kaOp, allOp, kaNid, allNid, 4'hA);
    writeEntry(1'b0, 5, 1'b1, '0, '0, '0, '0, '0, '0, 4'h1);
    writeEntry(1'b1, 7, 1'b1, k7Tag, allTag, k7Op, allOp, k7Nid, allNid, 4'h3);
`ifdef TCAM_HIT_CNT_EN
    checkOutput("hitCntClr", hit_cnt, 32'd0);
    checkOutput("missCntClr", miss_cnt, 32'd0);
`endif
    applyStimulus(kaTag, kaOp, kaNid, missRes);
    applyStimulus(kcTag, kcOp, kcNid, missRes);
    e.hit = 1'b1; e.idx = IDX_W'(7); e.flg = 4'h3;
    applyStimulus(k7Tag, k7Op, k7Nid, e);
    waitDrain();
    tick();
`ifdef TCAM_HIT_CNT_EN
    checkOutput("hitCnt", hit_cnt, 32'd1);
    checkOutput("missCnt", miss_cnt, 32'd2);
`endif

    monEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
